// File: rtl/pre_decode_queue_if.sv
// Fetch/sequencer handshake for the opcode pre-decode queue.
// The master modport is the fetch/sequencer side; the slave modport is the queue itself.
interface pre_decode_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] data_IN;
    logic              load_IN;
    logic              irq_IN;
    logic              pop_IN;
    logic              flush_IN;

    logic [DATA_W-1:0] preDecode_OUT;
    logic [1:0]        len_OUT;
    logic              int_OUT;
    logic              valid_OUT;
    logic              full_OUT;
    logic [CNT_W-1:0]  count_OUT;
    logic              ovf_OUT;

    modport master (
        output data_IN, load_IN, irq_IN, pop_IN, flush_IN,
        input  preDecode_OUT, len_OUT, int_OUT, valid_OUT, full_OUT, count_OUT, ovf_OUT
    );

    modport slave (
        input  data_IN, load_IN, irq_IN, pop_IN, flush_IN,
        output preDecode_OUT, len_OUT, int_OUT, valid_OUT, full_OUT, count_OUT, ovf_OUT
    );
endinterface

// File: rtl/pre_decode_queue.sv
// Opcode pre-decode FIFO: buffers fetched bytes and presents the head opcode with its
// instruction length, supporting branch flush and interrupt (BRK) injection.
module pre_decode_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                 phi2,
    input  logic                 rst_n,
    pre_decode_queue_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [DEPTH-1:0]  mem_int_q;

    logic              valid;
    logic              full;
    logic              do_pop;
    logic              do_write;
    logic [PTR_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] head_data;
    logic              head_int;
    logic [1:0]        head_len;

    // cc = 11 and the bbb/cc table map the 6502-style opcode map to 1..3 bytes.
    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [1:0] cc;
        logic [2:0] bbb;
        logic [1:0] len;
        cc  = op[1:0];
        bbb = op[4:2];
        len = 2'd2;
        case (cc)
            2'b01: len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
            2'b11: len = 2'd1;
            default: begin
                if (op == 8'h20) begin
                    len = 2'd3;
                end else if (op == 8'h00 || op == 8'h40 || op == 8'h60) begin
                    len = 2'd1;
                end else begin
                    case (bbb)
                        3'b000:         len = 2'd2;
                        3'b010, 3'b110: len = 2'd1;
                        3'b011, 3'b111: len = 2'd3;
                        default:        len = 2'd2;
                    endcase
                end
            end
        endcase
        return len;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        valid    = (count_q != '0);
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = bus.pop_IN & valid & ~bus.flush_IN;
        do_write = bus.load_IN & (bus.flush_IN | ~full | do_pop);
        wr_idx   = bus.flush_IN ? '0 : wr_ptr_q;
        wr_data  = bus.irq_IN ? '0 : bus.data_IN;

        if (bus.flush_IN) begin
            // The branch-target fetch arriving with the flush restarts the queue at slot 0.
            rd_ptr_d = '0;
            wr_ptr_d = bus.load_IN ? PTR_W'(1) : '0;
            count_d  = bus.load_IN ? CNT_W'(1) : '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({do_write, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (bus.load_IN & full & ~do_pop);
        end
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage has no reset; an empty count masks whatever stale data it holds.
    always_ff @(posedge phi2) begin
        if (do_write) begin
            mem_data_q[wr_idx] <= wr_data;
            mem_int_q[wr_idx]  <= bus.irq_IN;
        end
    end

    always_comb begin
        head_data = mem_data_q[rd_ptr_q];
        head_int  = mem_int_q[rd_ptr_q];
        head_len  = head_int ? 2'd1 : decode_len(head_data[7:0]);
    end

    assign bus.preDecode_OUT = valid ? head_data : '0;
    assign bus.len_OUT       = valid ? head_len : 2'd0;
    assign bus.int_OUT       = valid & head_int;
    assign bus.valid_OUT     = valid;
    assign bus.full_OUT      = full;
    assign bus.count_OUT     = count_q;
    assign bus.ovf_OUT       = ovf_q;

endmodule
